// File: rtl/rect_fill_master.sv
// Rectangle fill engine: CSR slave holds two corners and a colour; a start streams one pixel word per cell to a master port.
// Optional screen clipping (160x120) is enabled by defining RECT_FILL_CLIP_EN.
module rect_fill_master (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [3:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t     state;
  logic [7:0] xa, ya, xb, yb, colour;
  logic [7:0] xmin, xmax, ymin, ymax, x, y, col;
  logic       done;

  logic [7:0] lo_x, hi_x, lo_y, hi_y, nx, ny;
  logic       empty, last;
  logic       unused_bits;

  assign m_address   = 4'd0;
  assign unused_bits = ^writedata[31:16];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    lo_x  = (xa < xb) ? xa : xb;
    hi_x  = (xa < xb) ? xb : xa;
    lo_y  = (ya < yb) ? ya : yb;
    hi_y  = (ya < yb) ? yb : ya;
    empty = 1'b0;
`ifdef RECT_FILL_CLIP_EN
    empty = (lo_x > 8'd159) || (lo_y > 8'd119);
    if (hi_x > 8'd159) hi_x = 8'd159;
    if (hi_y > 8'd119) hi_y = 8'd119;
`endif
  end

  // Equality-terminated walk: an edge at 255 never needs the counter to wrap.
  always_comb begin
    last = (x == xmax) && (y == ymax);
    nx   = (x == xmax) ? xmin : x + 8'd1;
    ny   = (x == xmax) ? y + 8'd1 : y;
  end

  always_comb begin
    readdata = '0;
    if (read) begin
      case (address)
        4'd0:    readdata = {30'b0, done, (state == FILL)};
        4'd1:    readdata = {16'b0, ya, xa};
        4'd2:    readdata = {16'b0, yb, xb};
        4'd3:    readdata = {24'b0, colour};
        default: readdata = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the walk registers are reset too; the block is small and a clean post-reset state eases debug.
      state       <= IDLE;
      xa          <= '0;
      ya          <= '0;
      xb          <= '0;
      yb          <= '0;
      colour      <= '0;
      xmin        <= '0;
      xmax        <= '0;
      ymin        <= '0;
      ymax        <= '0;
      x           <= '0;
      y           <= '0;
      col         <= '0;
      done        <= 1'b0;
      m_write     <= 1'b0;
      m_writedata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write) begin
            case (address)
              4'd0: begin
                xmin        <= lo_x;
                xmax        <= hi_x;
                ymin        <= lo_y;
                ymax        <= hi_y;
                x           <= lo_x;
                y           <= lo_y;
                col         <= colour;
                done        <= 1'b0;
                state       <= FILL;
                m_write     <= !empty;
                m_writedata <= {lo_y, lo_x, 8'h00, colour};
              end
              4'd1:    {ya, xa} <= writedata[15:0];
              4'd2:    {yb, xb} <= writedata[15:0];
              4'd3:    colour   <= writedata[7:0];
              default: ;
            endcase
          end
        end
        FILL: begin
          // CSR writes are deliberately not decoded here: the fill cannot be disturbed.
          if (!m_write) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (!m_waitrequest) begin
            if (last) begin
              m_write <= 1'b0;
              state   <= IDLE;
              done    <= 1'b1;
            end else begin
              x           <= nx;
              y           <= ny;
              m_writedata <= {ny, nx, 8'h00, col};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_master.sv
// Randomised bench for rect_fill_master against a loop-based pixel list model; honours RECT_FILL_CLIP_EN like the RTL.
module tb_rect_fill_master;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  rect_fill_master dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .m_address(m_address),
    .m_write(m_write), .m_writedata(m_writedata), .m_waitrequest(m_waitrequest)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  int    mw_cycles;
  int    wr_mode = 0;   // 0: never stall, 1: random stalls, 2: stall first stall_left cycles
  int    stall_left = 0;
  logic  ref_done = 1'b0;
  logic  prev_stall = 1'b0;
  logic [31:0] prev_data;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (wr_mode)
      1: m_waitrequest = ($urandom_range(0, 2) == 0);
      2: begin
        if (m_write && stall_left > 0) begin
          m_waitrequest = 1'b1;
          stall_left--;
        end else m_waitrequest = 1'b0;
      end
      default: m_waitrequest = 1'b0;
    endcase
  end

  // Bus monitor: records accepted words and checks that stalled words stay put.
  always @(negedge clk) begin
    if (reset) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("hold_write", {31'b0, m_write}, 32'd1);
        check("hold_data", m_writedata, prev_data);
      end
      if (m_write) begin
        mw_cycles++;
        if (!m_waitrequest) got.push_back(m_writedata);
      end
      prev_stall = m_write && m_waitrequest;
      prev_data  = m_writedata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_csr(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    step();
    write = 1'b0;
  endtask

  task automatic rd_csr(input logic [3:0] a, output logic [31:0] v);
    address = a; read = 1'b1;
    #1;
    v = readdata;
    read = 1'b0;
  endtask

  // Reference: the list of words a fill must emit, from the corner rules alone.
  task automatic build_expected(input int xa, input int ya, input int xb, input int yb, input int c);
    int x0, x1, y0, y1;
    x0 = (xa < xb) ? xa : xb; x1 = (xa < xb) ? xb : xa;
    y0 = (ya < yb) ? ya : yb; y1 = (ya < yb) ? yb : ya;
`ifdef RECT_FILL_CLIP_EN
    if (x1 > 159) x1 = 159;
    if (y1 > 119) y1 = 119;
`endif
    exp_q.delete();
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++)
        exp_q.push_back((yy << 24) | (xx << 16) | (c & 8'hFF));
  endtask

  task automatic start_fill();
    address = 4'd0; writedata = 32'd1; write = 1'b1; read = 1'b1;
    #1;
    check("ctrl_rw_pre", readdata, {30'b0, ref_done, 1'b0});
    step();
    write = 1'b0; read = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int cyc = 0;
    address = 4'd0; read = 1'b1;
    #1;
    while (readdata[0] && cyc < bound) begin
      step();
      cyc++;
    end
    read = 1'b0;
    if (cyc >= bound) check("timeout", 32'd1, 32'd0);
  endtask

  task automatic run_fill(input int xa, input int ya, input int xb, input int yb, input int c,
                          input bit poke, input string tag);
    logic [31:0] v;
    wr_csr(4'd1, (ya << 8) | xa);
    wr_csr(4'd2, (yb << 8) | xb);
    wr_csr(4'd3, c);
    rd_csr(4'd1, v); check({tag, "_corner_a"}, v, (ya << 8) | xa);
    build_expected(xa, ya, xb, yb, c);
    got.delete();
    mw_cycles = 0;
    start_fill();
    if (poke && exp_q.size() >= 4) begin
      wr_csr(4'd1, 32'h0000FFFF);
      wr_csr(4'd3, 32'h000000AA);
      wr_csr(4'd0, 32'd1);
    end
    wait_idle(4 * exp_q.size() + 20);
    rd_csr(4'd0, v); check({tag, "_ctrl_done"}, v, 32'd2);
    ref_done = 1'b1;
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_px%0d", tag, i), got[i], exp_q[i]);
    if (poke) begin
      rd_csr(4'd1, v); check({tag, "_poke_a"}, v, (ya << 8) | xa);
      rd_csr(4'd3, v); check({tag, "_poke_col"}, v, c);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int xa, ya, xb, yb, t;
    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0; m_waitrequest = 1'b0;
    step(); step();
    check("rst_m_write", {31'b0, m_write}, 32'd0);
    check("rst_m_addr", {28'b0, m_address}, 32'd0);
    reset = 1'b0;
    step();
    check("rst_m_data", m_writedata, 32'd0);
    rd_csr(4'd0, v); check("rst_ctrl", v, 32'd0);
    rd_csr(4'd1, v); check("rst_corner_a", v, 32'd0);
    rd_csr(4'd3, v); check("rst_colour", v, 32'd0);
    wr_csr(4'd9, 32'h1234);
    rd_csr(4'd9, v); check("unmapped_rd", v, 32'd0);

    // Basic rectangle, then corners swapped: same stream.
    run_fill(10, 20, 12, 21, 8'h7F, 1'b0, "basic");
    if (got.size() == 6) begin
      check("basic_first", got[0], 32'h140A007F);
      check("basic_last", got[5], 32'h150C007F);
    end
    run_fill(12, 21, 10, 20, 8'h7F, 1'b0, "swapped");

    // Single pixel held for three stall cycles.
    wr_mode = 2; stall_left = 3;
    run_fill(5, 5, 5, 5, 8'h33, 1'b0, "single");
    check("single_hold_cycles", mw_cycles, 32'd4);
    wr_mode = 0;

    // Off-screen corner: clipped to 4 pixels or walked in full.
    run_fill(158, 118, 170, 130, 8'h5C, 1'b0, "clip");
`ifndef RECT_FILL_CLIP_EN
    if (got.size() == 169) check("clip_last", got[168], 32'h82AA005C);
`else
    // Fully off-screen: FILL lasts one cycle, no writes.
    run_fill(165, 10, 200, 20, 8'h11, 1'b0, "empty");
    wr_csr(4'd0, 32'd1);
    rd_csr(4'd0, v); check("empty_busy", v, 32'd1);
    step();
    rd_csr(4'd0, v); check("empty_done", v, 32'd2);
`endif

    // Counters touching 255.
    run_fill(250, 253, 255, 255, 8'hE1, 1'b0, "edge255");

    // Randomised rectangles with random stalls and mid-fill CSR pokes.
    wr_mode = 1;
    for (int i = 0; i < 16; i++) begin
      xa = $urandom_range(0, 255); ya = $urandom_range(0, 255);
      t = xa + $urandom_range(0, 5); xb = (t > 255) ? 255 : t;
      t = ya + $urandom_range(0, 4); yb = (t > 255) ? 255 : t;
      if (i < 6) begin xa = xa % 160; ya = ya % 120; xb = xa + $urandom_range(0, 4); yb = ya + 2; end
      if ($urandom_range(0, 1) == 1) begin t = xa; xa = xb; xb = t; end
      run_fill(xa, ya, xb, yb, $urandom_range(0, 255), (i % 3) == 0, $sformatf("rnd%0d", i));
    end
    wr_mode = 0;

    // Reset in the middle of a fill.
    wr_csr(4'd1, (20 << 8) | 10);
    wr_csr(4'd2, (21 << 8) | 12);
    wr_csr(4'd3, 32'h7F);
    got.delete();
    start_fill();
    t = 0;
    while (got.size() < 3 && t < 20) begin step(); t++; end
    check("mid_rst_reach3", got.size(), 32'd3);
    reset = 1'b1;
    #1;
    check("mid_rst_m_write", {31'b0, m_write}, 32'd0);
    rd_csr(4'd0, v); check("mid_rst_ctrl", v, 32'd0);
    step();
    reset = 1'b0;
    ref_done = 1'b0;
    repeat (10) step();
    check("mid_rst_no_more", got.size(), 32'd3);
    rd_csr(4'd0, v); check("mid_rst_ctrl_after", v, 32'd0);
    rd_csr(4'd2, v); check("mid_rst_corner_b", v, 32'd0);
    run_fill(3, 4, 6, 5, 8'h42, 1'b0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
